latch_share_arbiter: RTL and testbench
======================================

Name: latch_share_arbiter

Overview:
- Round-robin arbiter that shares one capture register (a DW-bit `out <= in` storage element) among N_REQ requesters.
- Selects one requester and captures its data word into the shared register.
- Holds the captured word valid for HOLD_CYC cycles, then re-arbitrates.
- Sits between several producer blocks and a single downstream consumer of the registered value.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- DW, 8, data width per requester.
- HOLD_CYC, 2, cycles out_valid stays high per grant (>=1).
- SW (localparam), max(1, clog2(N_REQ)), width of out_src.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbitration enable; low blocks new grants.
- req  input  N_REQ  level request, one bit per requester.
- req_data  input  N_REQ*DW  packed data; requester i occupies bits [i*DW +: DW].
- gnt  output  N_REQ  one-hot grant pulse, one cycle wide, registered.
- out_data  output  DW  shared capture register.
- out_src  output  SW  index of the requester whose data is in out_data.
- out_valid  output  1  out_data is fresh; high for HOLD_CYC cycles per grant.

Behaviour:
- Reset (async, any time, including mid-HOLD): gnt=0, out_data=0, out_src=0, out_valid=0, state=IDLE, hold_cnt=0, rr pointer ptr=0. Takes effect immediately, not at the next edge.
- States: IDLE and HOLD.
- A decision edge is either:
  - any rising edge in IDLE, or
  - a rising edge in HOLD with hold_cnt==0.
- Grant condition at a decision edge: en==1 and |req==1.
- Selection: first set req bit scanning ptr, ptr+1, … N_REQ-1, 0, … ptr-1 (wrap-around). Call it sel.
- On a grant (all registered at that edge):
  - gnt <= onehot(sel)
  - out_data <= req_data[sel]
  - out_src <= sel
  - out_valid <= 1
  - hold_cnt <= HOLD_CYC-1
  - state <= HOLD
  - ptr <= (sel+1) mod N_REQ
- Latency: req and data sampled at a decision edge appear on gnt, out_data and out_valid in the following cycle.
- At a decision edge with no grant: out_valid <= 0, state <= IDLE. out_data and out_src keep their last values.
- HOLD, hold_cnt>0: gnt <= 0, hold_cnt decrements, out_valid stays 1, out_data is frozen.
- Continuous requests produce back-to-back grants exactly HOLD_CYC cycles apart, with out_valid never dropping.
- gnt is high for exactly one cycle per grant, and never high while state is IDLE after a no-grant edge.
- Requester protocol:
  - req is level; gnt is the acknowledge.
  - A requester keeping req high after gnt is re-eligible, but only at lowest priority, so there is no starvation.
  - req_data[i] must be stable in the cycle req[i] is sampled at a decision edge.
- en:
  - en low suppresses new grants only; an in-progress HOLD completes normally.
  - en low at a decision edge behaves as the no-grant case.
- Changes to req or req_data during HOLD are ignored until the next decision edge.
- ptr changes only on a grant or on reset.

Test Plan (N_REQ=4, DW=8, HOLD_CYC=2 unless noted):
1. Reset check: assert rst asynchronously with no clock edge -> all outputs 0 immediately. Release rst with req=0 -> outputs stay 0, out_valid=0.
2. Single requester: req=0100 held, req_data[2]=0xA5 ->
   - gnt=0100 one cycle after the first sampling edge;
   - out_data=0xA5, out_src=2, out_valid high continuously;
   - gnt=0100 pulses every 2 cycles.
3. Fairness: req=1111 held, data 0x10/0x11/0x12/0x13 -> out_src sequence 0,1,2,3,0, one step per 2 cycles, out_data following 0x10,0x11,0x12,0x13,0x10.
4. Enable gating: en=0 with req=0001 for 5 cycles -> gnt=0, out_valid=0. Raise en -> gnt=0001 on the following cycle. Drop en mid-HOLD -> out_valid still lasts 2 cycles, then goes 0.
5. Reset mid-operation: rst mid-HOLD after a grant to 1 -> immediate clear, ptr=0. Then req=1010 -> grant goes to 1 (scan starts at 0), then to 3.
6. HOLD_CYC=1, req=0011 held -> gnt alternates 0001, 0010 every cycle, out_valid constant 1, out_src toggles 0,1.

Source files
------------

// File: rtl/latch_share_arbiter.sv
// Round-robin arbiter that shares one capture register among N_REQ requesters.
// Each grant captures the selected word and holds it valid for HOLD_CYC cycles.
module latch_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DW       = 8,
  parameter int HOLD_CYC = 2,
  localparam int SW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      gnt,
  output logic [DW-1:0]         out_data,
  output logic [SW-1:0]         out_src,
  output logic                  out_valid
);

  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_q;
  logic [CW-1:0]      hold_cnt_q;
  logic [SW-1:0]      ptr_q;
  logic [SW-1:0]      ptr_d;
  logic [N_REQ-1:0]   gnt_q;
  logic [DW-1:0]      out_data_q;
  logic [SW-1:0]      out_src_q;
  logic               out_valid_q;

  logic [SW-1:0]      sel;
  logic               found;
  logic               decision;
  logic               grant;
  int unsigned        idx;

  // Wrap-around scan starting at ptr_q; the first set bit wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = SW'(idx);
      end
    end
  end

  always_comb begin
    decision = (state_q == IDLE) || (hold_cnt_q == '0);
    grant    = decision && en && found;
    ptr_d    = (32'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (grant) begin
      state_q     <= HOLD;
      hold_cnt_q  <= CW'(HOLD_CYC - 1);
      ptr_q       <= ptr_d;
      gnt_q       <= N_REQ'(1) << sel;
      out_data_q  <= req_data[sel*DW +: DW];
      out_src_q   <= sel;
      out_valid_q <= 1'b1;
    end else if (decision) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      gnt_q       <= '0;
      hold_cnt_q  <= hold_cnt_q - 1'b1;
    end
  end

  assign gnt       = gnt_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_latch_share_arbiter.sv
// Directed bench for latch_share_arbiter: one DUT with HOLD_CYC=2, one with HOLD_CYC=1.
module tb_latch_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  req2 = '0;
  logic [31:0] req_data = '0;

  logic [3:0]  gnt, gnt2;
  logic [7:0]  out_data, out_data2;
  logic [1:0]  out_src, out_src2;
  logic        out_valid, out_valid2;

  int checks   = 0;
  int failures = 0;

  latch_share_arbiter #(.N_REQ(4), .DW(8), .HOLD_CYC(2)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
    .gnt(gnt), .out_data(out_data), .out_src(out_src), .out_valid(out_valid)
  );

  latch_share_arbiter #(.N_REQ(4), .DW(8), .HOLD_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req2), .req_data(req_data),
    .gnt(gnt2), .out_data(out_data2), .out_src(out_src2), .out_valid(out_valid2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [7:0] d,
                         input logic [1:0] s, input logic v);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".data"}, 32'(out_data), 32'(d));
    chk({tag, ".src"}, 32'(out_src), 32'(s));
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    // 1. async reset with no clock edge
    #2 rst = 1'b1;
    #1;
    chk_all("rst_async", 4'b0000, 8'h00, 2'd0, 1'b0);
    chk_all("rst_async_b", 4'b0000, 8'h00, 2'd0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk_all("rst_release", 4'b0000, 8'h00, 2'd0, 1'b0);
    tick();
    chk_all("rst_idle", 4'b0000, 8'h00, 2'd0, 1'b0);

    // 2. single requester 2, ptr starts at 0
    en = 1'b1;
    req = 4'b0100;
    req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    tick();
    chk_all("single_g1", 4'b0100, 8'hA5, 2'd2, 1'b1);
    tick();
    chk_all("single_h1", 4'b0000, 8'hA5, 2'd2, 1'b1);
    tick();
    chk_all("single_g2", 4'b0100, 8'hA5, 2'd2, 1'b1);
    tick();
    chk_all("single_h2", 4'b0000, 8'hA5, 2'd2, 1'b1);
    req = 4'b0000;
    tick();
    chk_all("single_drop", 4'b0000, 8'hA5, 2'd2, 1'b0);

    // 3. fairness from ptr=0 with all requesting
    pulse_rst();
    req = 4'b1111;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    tick();
    chk_all("rr_0", 4'b0001, 8'h10, 2'd0, 1'b1);
    tick();
    chk_all("rr_0h", 4'b0000, 8'h10, 2'd0, 1'b1);
    tick();
    chk_all("rr_1", 4'b0010, 8'h11, 2'd1, 1'b1);
    tick();
    chk("rr_1h.valid", 32'(out_valid), 32'd1);
    tick();
    chk_all("rr_2", 4'b0100, 8'h12, 2'd2, 1'b1);
    tick();
    chk("rr_2h.valid", 32'(out_valid), 32'd1);
    tick();
    chk_all("rr_3", 4'b1000, 8'h13, 2'd3, 1'b1);
    tick();
    chk("rr_3h.valid", 32'(out_valid), 32'd1);
    tick();
    chk_all("rr_wrap", 4'b0001, 8'h10, 2'd0, 1'b1);

    // 4. enable gating
    pulse_rst();
    en = 1'b0;
    req = 4'b0001;
    req_data = {8'h00, 8'h00, 8'h00, 8'h5C};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("en_off.gnt", 32'(gnt), 32'd0);
      chk("en_off.valid", 32'(out_valid), 32'd0);
    end
    en = 1'b1;
    tick();
    chk_all("en_on", 4'b0001, 8'h5C, 2'd0, 1'b1);
    en = 1'b0;
    tick();
    chk_all("en_drop_h", 4'b0000, 8'h5C, 2'd0, 1'b1);
    tick();
    chk_all("en_drop_end", 4'b0000, 8'h5C, 2'd0, 1'b0);
    tick();
    chk("en_drop_idle.gnt", 32'(gnt), 32'd0);

    // 5. reset mid-HOLD clears ptr
    pulse_rst();
    en = 1'b1;
    req = 4'b0010;
    req_data = {8'h23, 8'h00, 8'h21, 8'h00};
    tick();
    chk_all("mid_g", 4'b0010, 8'h21, 2'd1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_all("mid_rst", 4'b0000, 8'h00, 2'd0, 1'b0);
    rst = 1'b0;
    req = 4'b1010;
    tick();
    chk_all("post_rst_1", 4'b0010, 8'h21, 2'd1, 1'b1);
    tick();
    chk("post_rst_h.gnt", 32'(gnt), 32'd0);
    tick();
    chk_all("post_rst_3", 4'b1000, 8'h23, 2'd3, 1'b1);

    // 6. HOLD_CYC=1 instance
    req = 4'b0000;
    pulse_rst();
    req2 = 4'b0011;
    req_data = {8'h00, 8'h00, 8'h31, 8'h30};
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("h1.gnt", 32'(gnt2), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("h1.src", 32'(out_src2), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("h1.data", 32'(out_data2), (i % 2 == 0) ? 32'h30 : 32'h31);
      chk("h1.valid", 32'(out_valid2), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
